act_scan_ctrl: RTL and testbench

- Scan controller that sits directly upstream and downstream of the registered ACT S2 cell.
- Drives the S2 select inputs A1/B1/A0/B0 through a masked round-robin over D0..D3 for a programmable number of passes.
- Consumes the registered S2 `out` and accumulates it into a saturating sum.
- Start/busy/done handshake toward the host datapath.

---
 rtl/act_pkg.sv | 32 +++
 rtl/sat_accumulator.sv | 35 +++
 rtl/act_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_act_scan_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared state encoding, latency constants and slot-walk helpers for the ACT scan controller
package act_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int S2_LATENCY = 2;
    localparam int NUM_SLOTS  = 4;

    // Next enabled slot strictly after cur in ascending order, wrapping D3->D0.
    function automatic logic [1:0] next_slot(input logic [NUM_SLOTS-1:0] m, input logic [1:0] cur);
        logic [1:0] s;
        next_slot = cur;
        for (int i = NUM_SLOTS; i >= 1; i--) begin
            s = cur + 2'(i);
            if (m[s]) next_slot = s;
        end
    endfunction

    // True when no enabled slot lies above cur, i.e. the next issue starts a new pass.
    function automatic logic slot_wraps(input logic [NUM_SLOTS-1:0] m, input logic [1:0] cur);
        slot_wraps = 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (i > int'(cur) && m[i]) slot_wraps = 1'b0;
        end
    endfunction

endpackage

// File: rtl/sat_accumulator.sv
// rtl/sat_accumulator.sv - saturating accumulator with sticky overflow flag
module sat_accumulator #(
    parameter int size  = 5,
    parameter int ACC_W = 9
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             clear,
    input  logic             add_en,
    input  logic [size-1:0]  data,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam int W1 = ACC_W + 1;

    logic [ACC_W:0] total;

    always_comb total = {1'b0, sum} + W1'(data);

    always_ff @(posedge clk) begin
        if (CLR || clear) begin
            sum <= '0;
            ovf <= 1'b0;
        end else if (add_en) begin
            if (total[ACC_W]) begin
                sum <= '1;
                ovf <= 1'b1;
            end else begin
                sum <= total[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/act_scan_ctrl.sv
// rtl/act_scan_ctrl.sv - masked round-robin scan of the S2 cell with saturating accumulation
module act_scan_ctrl
    import act_pkg::*;
#(
    parameter int size  = 5,
    parameter int ACC_W = 9,
    parameter int N_W   = 4
) (
    input  logic                 clk,
    input  logic                 CLR,
    input  logic                 start,
    input  logic [NUM_SLOTS-1:0] mask,
    input  logic [N_W-1:0]       passes,
    input  logic [size-1:0]      s2_out,
    output logic                 A1,
    output logic                 B1,
    output logic                 A0,
    output logic                 B0,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_W-1:0]     sum,
    output logic                 ovf
);

    state_t                 state;
    logic [NUM_SLOTS-1:0]   mask_q;
    logic [N_W-1:0]         pass_left;
    logic [1:0]             cur;
    logic [S2_LATENCY-1:0]  vld;

    logic                   accept;
    logic                   k_zero;
    logic [1:0]             first;
    logic                   first_last;
    logic [1:0]             nxt;
    logic [N_W-1:0]         pass_dec;
    logic                   nxt_last;

    always_comb begin
        accept     = (state == IDLE) && start;
        k_zero     = (mask == '0) || (passes == '0);
        first      = next_slot(mask, 2'd3);
        first_last = (passes == N_W'(1)) && slot_wraps(mask, first);
        nxt        = next_slot(mask_q, cur);
        pass_dec   = slot_wraps(mask_q, cur) ? pass_left - N_W'(1) : pass_left;
        // The issue being made now is the last one when its successor would open a pass we do not have.
        nxt_last   = (pass_dec == N_W'(1)) && slot_wraps(mask_q, nxt);
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state     <= IDLE;
            {A1, B1}  <= 2'b00;
            {A0, B0}  <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            vld       <= '0;
            cur       <= 2'd0;
            mask_q    <= '0;
            pass_left <= '0;
        end else begin
            vld  <= {vld[S2_LATENCY-2:0], 1'b0};
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q    <= mask;
                        pass_left <= passes;
                        busy      <= 1'b1;
                        if (!k_zero) begin
                            cur      <= first;
                            {A1, B1} <= {2{first[1]}};
                            {A0, B0} <= {2{first[0]}};
                            vld[0]   <= 1'b1;
                            state    <= first_last ? DRAIN : ISSUE;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                ISSUE: begin
                    cur       <= nxt;
                    {A1, B1}  <= {2{nxt[1]}};
                    {A0, B0}  <= {2{nxt[0]}};
                    vld[0]    <= 1'b1;
                    pass_left <= pass_dec;
                    if (nxt_last) state <= DRAIN;
                end
                DRAIN: begin
                    // The oldest in-flight sample is added on this same edge.
                    if (vld[S2_LATENCY-2:0] == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    {A1, B1} <= 2'b00;
                    {A0, B0} <= 2'b00;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_accumulator #(
        .size  (size),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk    (clk),
        .CLR    (CLR),
        .clear  (accept),
        .add_en (vld[S2_LATENCY-1]),
        .data   (s2_out),
        .sum    (sum),
        .ovf    (ovf)
    );

endmodule

// File: tb/tb_act_scan_ctrl.sv
// tb/tb_act_scan_ctrl.sv - directed self-checking bench for act_scan_ctrl with a registered S2 model
module tb_act_scan_ctrl;

    logic       clk;
    logic       CLR;
    logic       start;
    logic [3:0] mask;
    logic [3:0] passes;
    logic [4:0] s2_out;
    logic       A1, B1, A0, B0;
    logic       busy, done, ovf;
    logic [8:0] sum;

    logic [4:0]  d [4];
    logic [1:0]  slot_idx;
    logic [15:0] sel_trace;
    logic        sel_ok;
    int          checks;
    int          errors;

    act_scan_ctrl #(.size(5), .ACC_W(9), .N_W(4)) dut (
        .clk    (clk),
        .CLR    (CLR),
        .start  (start),
        .mask   (mask),
        .passes (passes),
        .s2_out (s2_out),
        .A1     (A1),
        .B1     (B1),
        .A0     (A0),
        .B0     (B0),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign slot_idx = {A1 | B1, A0 & B0};
    always_ff @(posedge clk) s2_out <= d[slot_idx];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start at the next edge (edge 0), corrupt mask/passes while busy, wait for done.
    task automatic run_scan(input logic [3:0] m, input logic [3:0] p, input int exp_edge,
                            input logic [8:0] exp_sum, input logic exp_ovf, input string tag);
        int de;
        mask = m; passes = p; start = 1'b1;
        sel_trace = '0; sel_ok = 1'b1; de = -1;
        for (int e = 0; e < 100; e++) begin
            tick();
            if (e == 0) begin
                start = 1'b0; mask = ~m; passes = p + 4'd3;
            end
            if (e < 8) sel_trace[2*e +: 2] = slot_idx;
            if (A1 !== B1 || A0 !== B0) sel_ok = 1'b0;
            if (done === 1'b1) begin
                de = e;
                break;
            end
        end
        chk({tag, "_done_edge"}, de, exp_edge);
        chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, "_busy_at_done"}, 32'(busy), 0);
        chk({tag, "_sel_pairs"}, 32'(sel_ok), 1);
        tick();
        chk({tag, "_done_pulse_width"}, 32'(done), 0);
    endtask

    initial begin
        int dones;
        int de;
        logic busy_at6;
        checks = 0; errors = 0;
        CLR = 1'b1; start = 1'b0; mask = 4'h0; passes = 4'h0;
        d[0] = 5'd3; d[1] = 5'd5; d[2] = 5'd7; d[3] = 5'd11;
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_sel", 32'({A1, B1, A0, B0}), 0);
        CLR = 1'b0;
        tick();

        run_scan(4'b1111, 4'd1, 5, 9'd26, 1'b0, "basic");
        chk("basic_sel_walk", 32'(sel_trace), 32'h0FE4);

        run_scan(4'b0101, 4'd3, 7, 9'd30, 1'b0, "masked");
        chk("masked_sel_walk", 32'(sel_trace), 32'hA888);

        run_scan(4'b0000, 4'd5, 1, 9'd0, 1'b0, "empty_mask");
        chk("empty_mask_sel", 32'(sel_trace), 0);
        run_scan(4'b1111, 4'd0, 1, 9'd0, 1'b0, "empty_pass");
        chk("empty_pass_sel", 32'(sel_trace), 0);

        // Extra starts sampled at edge 2 (ISSUE) and edge 6 (DONE) must be ignored.
        mask = 4'b1111; passes = 4'd1; start = 1'b1;
        dones = 0; de = -1; busy_at6 = 1'bx;
        for (int e = 0; e < 12; e++) begin
            tick();
            start = (e == 1 || e == 5);
            if (done === 1'b1) begin
                dones++;
                if (de < 0) de = e;
            end
            if (e == 7) busy_at6 = busy;
        end
        chk("hs_done_count", dones, 1);
        chk("hs_done_edge", de, 5);
        chk("hs_busy_after_ignored", 32'(busy_at6), 0);
        chk("hs_sum_held", 32'(sum), 26);
        run_scan(4'b1111, 4'd1, 5, 9'd26, 1'b0, "hs_restart");

        // Back-to-back: start sampled in the IDLE cycle right after done.
        run_scan(4'b1111, 4'd1, 5, 9'd26, 1'b0, "b2b");

        mask = 4'b1111; passes = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("clr_busy", 32'(busy), 0);
        chk("clr_sum", 32'(sum), 0);
        chk("clr_sel", 32'({A1, B1, A0, B0}), 0);
        dones = 0;
        for (int e = 0; e < 8; e++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        chk("clr_no_done", dones, 0);
        run_scan(4'b1111, 4'd1, 5, 9'd26, 1'b0, "clr_restart");

        d[0] = 5'd31; d[1] = 5'd31; d[2] = 5'd31; d[3] = 5'd31;
        run_scan(4'b1111, 4'd15, 61, 9'd511, 1'b1, "sat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
